// File: rtl/mactx_framer.sv
// mactx_framer: SLINK MAC transmit framer.
//
// Pulls SOP/EOP-tagged words from the TX packet buffer using a read handshake
// with one cycle of latency. Each word is sent as a byte stream, MSB byte
// first. The stream is wrapped as:
//   preamble/SFD -> payload -> optional zero padding -> CRC-32 FCS
//   -> end delimiter -> inter-packet gap
// Underruns and protocol errors end the frame early with an error delimiter.
//
// Ports
//   clk_12_5m  system clock
//   rst_12_5m  asynchronous reset, active low
//   in_data    {sop, eop, payload}, payload MSB byte sent first
//   in_dval    in_data valid, the cycle after in_rdreq
//   in_rdreq   word request to the buffer
//   out_data   byte to PCS, 8'h00 whenever out_dval is low
//   out_dval   byte valid, preamble through delimiter inclusive
//   tx_eop     one-cycle pulse alongside the delimiter byte
//   tx_err     one-cycle pulse on abort or on a dropped non-SOP word
//   tx_busy    high in every state except IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | poll the buffer; wait for an SOP word
// PRE   | send PRE_LEN-1 bytes of 8'h55, then the 8'hD5 SFD
// DATA  | shift the held word out; fetch the next word just in time
// PAD   | send 8'h00 until the payload reaches MIN_PAYLOAD
// FCS   | send the inverted CRC register, low byte first
// EOD   | send EOD_OK, or EOD_ERR after an abort; pulse tx_eop
// IPG   | idle gap before the buffer is polled again
//
// Outputs are registered from the current state. A byte therefore appears
// one cycle after the state that chose it.

module mactx_framer #(
  parameter int         IN_BYTES    = 2,
  parameter int         PRE_LEN     = 8,
  parameter int         IPG_LEN     = 11,
  parameter int         MIN_PAYLOAD = 0,
  parameter logic [7:0] EOD_OK      = 8'hFD,
  parameter logic [7:0] EOD_ERR     = 8'hFE
) (
  input  logic                    clk_12_5m,
  input  logic                    rst_12_5m,
  input  logic [8*IN_BYTES+1:0]   in_data,
  input  logic                    in_dval,
  output logic                    in_rdreq,
  output logic [7:0]              out_data,
  output logic                    out_dval,
  output logic                    tx_eop,
  output logic                    tx_err,
  output logic                    tx_busy
);

  localparam int          PW        = 8 * IN_BYTES;
  localparam logic [7:0]  PRE_LAST  = 8'(PRE_LEN - 1);
  localparam logic [7:0]  BYTE_LAST = 8'(IN_BYTES - 1);
  localparam logic [7:0]  IPG_CNT   = 8'(IPG_LEN);
  localparam logic [31:0] MIN_P     = 32'(MIN_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAD,
    FCS,
    EOD,
    IPG
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] held_q, held_d;
  logic          held_eop_q, held_eop_d;
  logic [31:0]   crc_q, crc_d;
  logic [15:0]   pay_q, pay_d;
  logic          abort_q, abort_d;
  logic          armed_q;

  logic [7:0]    out_data_d;
  logic          out_dval_d;
  logic          tx_eop_d;
  logic          tx_err_d;

  logic          in_sop;
  logic          in_eop;
  logic [PW-1:0] in_payload;
  logic [7:0]    top_byte;
  logic [15:0]   pay_inc;

  assign in_sop     = in_data[PW+1];
  assign in_eop     = in_data[PW];
  assign in_payload = in_data[PW-1:0];
  assign top_byte   = held_q[PW-1 -: 8];
  assign pay_inc    = (pay_q == 16'hFFFF) ? pay_q : pay_q + 16'd1;
  assign tx_busy    = (state_q != IDLE);

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    held_eop_d = held_eop_q;
    crc_d      = crc_q;
    pay_d      = pay_q;
    abort_d    = abort_q;
    out_data_d = 8'h00;
    out_dval_d = 1'b0;
    tx_eop_d   = 1'b0;
    tx_err_d   = 1'b0;
    in_rdreq   = 1'b0;

    case (state_q)
      IDLE: begin
        // armed_q keeps the request low while reset is held, and for the
        // first cycle after it is released.
        in_rdreq = armed_q & ~in_dval;
        if (in_dval) begin
          if (in_sop) begin
            held_d     = in_payload;
            held_eop_d = in_eop;
            crc_d      = 32'hFFFFFFFF;
            pay_d      = 16'd0;
            abort_d    = 1'b0;
            cnt_d      = PRE_LAST;
            state_d    = PRE;
          end else begin
            tx_err_d = 1'b1;
          end
        end
      end

      PRE: begin
        out_dval_d = 1'b1;
        if (cnt_q == 8'd0) begin
          out_data_d = 8'hD5;
          cnt_d      = BYTE_LAST;
          state_d    = DATA;
        end else begin
          out_data_d = 8'h55;
          cnt_d      = cnt_q - 8'd1;
        end
      end

      DATA: begin
        out_dval_d = 1'b1;
        out_data_d = top_byte;
        crc_d      = crc32_byte(crc_q, top_byte);
        pay_d      = pay_inc;
        held_d     = held_q << 8;
        // Request two bytes ahead, so the word arrives while the current
        // word's last byte is going out.
        if (cnt_q == 8'd1 && !held_eop_q) begin
          in_rdreq = 1'b1;
        end
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (held_eop_q) begin
          if ({16'd0, pay_inc} < MIN_P) begin
            state_d = PAD;
          end else begin
            cnt_d   = 8'd3;
            state_d = FCS;
          end
        end else if (in_dval && !in_sop) begin
          held_d     = in_payload;
          held_eop_d = in_eop;
          cnt_d      = BYTE_LAST;
        end else begin
          // Underrun, or a stray SOP word. The word is dropped.
          abort_d = 1'b1;
          state_d = EOD;
        end
      end

      PAD: begin
        out_dval_d = 1'b1;
        out_data_d = 8'h00;
        crc_d      = crc32_byte(crc_q, 8'h00);
        pay_d      = pay_inc;
        if ({16'd0, pay_inc} >= MIN_P) begin
          cnt_d   = 8'd3;
          state_d = FCS;
        end
      end

      FCS: begin
        out_dval_d = 1'b1;
        out_data_d = ~crc_q[7:0];
        // Shift the next FCS byte down. Ones are shifted in; the register
        // is reloaded at the next SOP.
        crc_d      = {8'hFF, crc_q[31:8]};
        if (cnt_q == 8'd0) begin
          state_d = EOD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      EOD: begin
        out_dval_d = 1'b1;
        out_data_d = abort_q ? EOD_ERR : EOD_OK;
        tx_eop_d   = 1'b1;
        tx_err_d   = abort_q;
        // The first IPG cycle overlaps the delimiter byte on the output, so
        // IPG_LEN+1 cycles are counted here.
        cnt_d      = IPG_CNT;
        state_d    = IPG;
      end

      IPG: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      held_q     <= '0;
      held_eop_q <= 1'b0;
      crc_q      <= 32'hFFFFFFFF;
      pay_q      <= 16'd0;
      abort_q    <= 1'b0;
      armed_q    <= 1'b0;
      out_data   <= 8'h00;
      out_dval   <= 1'b0;
      tx_eop     <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      held_eop_q <= held_eop_d;
      crc_q      <= crc_d;
      pay_q      <= pay_d;
      abort_q    <= abort_d;
      armed_q    <= 1'b1;
      out_data   <= out_data_d;
      out_dval   <= out_dval_d;
      tx_eop     <= tx_eop_d;
      tx_err     <= tx_err_d;
    end
  end

endmodule

// File: tb/tb_mactx_framer.sv
module tb_mactx_framer;

  logic clk_12_5m = 1'b0;
  logic rst_12_5m;
  always #40 clk_12_5m = ~clk_12_5m;

  // DUT A: 2-byte words, minimum payload 4
  logic [17:0] in_data2;
  logic        in_dval2, in_rdreq2, out_dval2, tx_eop2, tx_err2, tx_busy2;
  logic [7:0]  out_data2;
  // DUT B: 4-byte words, no padding
  logic [33:0] in_data4;
  logic        in_dval4, in_rdreq4, out_dval4, tx_eop4, tx_err4, tx_busy4;
  logic [7:0]  out_data4;

  mactx_framer #(.IN_BYTES(2), .MIN_PAYLOAD(4)) dut2 (
    .clk_12_5m(clk_12_5m), .rst_12_5m(rst_12_5m),
    .in_data(in_data2), .in_dval(in_dval2), .in_rdreq(in_rdreq2),
    .out_data(out_data2), .out_dval(out_dval2),
    .tx_eop(tx_eop2), .tx_err(tx_err2), .tx_busy(tx_busy2));

  mactx_framer #(.IN_BYTES(4)) dut4 (
    .clk_12_5m(clk_12_5m), .rst_12_5m(rst_12_5m),
    .in_data(in_data4), .in_dval(in_dval4), .in_rdreq(in_rdreq4),
    .out_data(out_data4), .out_dval(out_dval4),
    .tx_eop(tx_eop4), .tx_err(tx_err4), .tx_busy(tx_busy4));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drops2 = 0;
  logic [17:0] buf2[$];
  logic [33:0] buf4[$];
  // Scoreboard entries: {first_byte, eop, err, data}
  logic [10:0] exp2[$];
  logic [10:0] exp4[$];
  logic [7:0]  pl[$];
  int          rq4[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Non-reflected CRC-32 fed LSB first; bit-reversed at the end.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ r[31];
      r  = r << 1;
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Build the expected byte stream for the payload currently in pl.
  task automatic exp_frame(input int sel, input int minp, input bit abort);
    logic [10:0] q[$];
    logic [31:0] c;
    logic [31:0] res;
    int          n;
    for (int i = 0; i < 7; i++) q.push_back({(i == 0), 2'b00, 8'h55});
    q.push_back({3'b000, 8'hD5});
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      q.push_back({3'b000, pl[i]});
      c = crc_model(c, pl[i]);
    end
    if (abort) begin
      q.push_back({3'b011, 8'hFE});
    end else begin
      n = pl.size();
      while (n < minp) begin
        q.push_back({3'b000, 8'h00});
        c = crc_model(c, 8'h00);
        n++;
      end
      res = ~rev32(c);
      for (int i = 0; i < 4; i++) q.push_back({3'b000, res[8*i +: 8]});
      q.push_back({3'b010, 8'hFD});
    end
    foreach (q[i]) begin
      if (sel == 2) exp2.push_back(q[i]);
      else          exp4.push_back(q[i]);
    end
  endtask

  task automatic wait_exp(input int sel, input string tag);
    int n;
    n = 0;
    while (((sel == 2) ? exp2.size() : exp4.size()) != 0 && n < 500) begin
      @(posedge clk_12_5m);
      n++;
    end
    chk(tag, 32'(n < 500), 1);
  endtask

  task automatic wait_idle(input int sel, input string tag);
    int n;
    n = 0;
    while (((sel == 2) ? tx_busy2 : tx_busy4) && n < 100) begin
      @(posedge clk_12_5m);
      n++;
    end
    chk(tag, 32'(n < 100), 1);
    repeat (3) @(posedge clk_12_5m);
  endtask

  initial forever begin
    @(posedge clk_12_5m);
    cyc++;
  end

  // Packet buffer models: answer a request with data on the following cycle.
  initial begin
    logic r;
    in_dval2 = 1'b0;
    in_data2 = '0;
    forever begin
      @(negedge clk_12_5m);
      r = in_rdreq2;
      @(posedge clk_12_5m);
      #1;
      if (r && buf2.size() > 0) begin
        in_dval2 = 1'b1;
        in_data2 = buf2.pop_front();
      end else begin
        in_dval2 = 1'b0;
        in_data2 = '0;
      end
    end
  end

  initial begin
    logic r;
    in_dval4 = 1'b0;
    in_data4 = '0;
    forever begin
      @(negedge clk_12_5m);
      r = in_rdreq4;
      @(posedge clk_12_5m);
      #1;
      if (r && buf4.size() > 0) begin
        in_dval4 = 1'b1;
        in_data4 = buf4.pop_front();
      end else begin
        in_dval4 = 1'b0;
        in_data4 = '0;
      end
    end
  end

  // Output monitors: pop the scoreboard on every valid byte.
  initial begin
    logic [10:0] e;
    logic        prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_12_5m);
      if (out_dval2) begin
        if (exp2.size() == 0) begin
          chk("a_extra_byte", out_dval2, 0);
        end else begin
          e = exp2.pop_front();
          chk("a_byte", out_data2, e[7:0]);
          chk("a_eop", tx_eop2, e[9]);
          chk("a_err", tx_err2, e[8]);
          if (!e[10]) chk("a_gap", prev, 1);
        end
      end else begin
        chk("a_idle_data", out_data2, 0);
        chk("a_idle_eop", tx_eop2, 0);
        if (tx_err2) drops2++;
      end
      prev = out_dval2;
    end
  end

  initial begin
    logic [10:0] e;
    logic        prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_12_5m);
      if (out_dval4) begin
        if (exp4.size() == 0) begin
          chk("b_extra_byte", out_dval4, 0);
        end else begin
          e = exp4.pop_front();
          chk("b_byte", out_data4, e[7:0]);
          chk("b_eop", tx_eop4, e[9]);
          chk("b_err", tx_err4, e[8]);
          if (!e[10]) chk("b_gap", prev, 1);
        end
      end else begin
        chk("b_idle_data", out_data4, 0);
        chk("b_idle_eop", tx_eop4, 0);
        chk("b_idle_err", tx_err4, 0);
      end
      if (in_rdreq4 && tx_busy4) rq4.push_back(cyc);
      prev = out_dval4;
    end
  end

  initial begin
    #(80 * 40000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    rst_12_5m = 1'b0;
    repeat (3) @(posedge clk_12_5m);
    @(negedge clk_12_5m);
    chk("rst_data", out_data2, 0);
    chk("rst_dval", out_dval2, 0);
    chk("rst_eop", tx_eop2, 0);
    chk("rst_err", tx_err2, 0);
    chk("rst_busy", tx_busy2, 0);
    chk("rst_rdreq", in_rdreq2, 0);
    chk("rst_b_dval", out_dval4, 0);
    chk("rst_b_rdreq", in_rdreq4, 0);
    rst_12_5m = 1'b1;
    repeat (3) @(posedge clk_12_5m);

    // Two zero words, no padding needed, then an 11-cycle gap
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'h00);
    exp_frame(2, 4, 1'b0);
    buf2.push_back({2'b10, 16'h0000});
    buf2.push_back({2'b01, 16'h0000});
    wait_exp(2, "t1_drain");
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_12_5m);
      chk("t1_ipg_dval", out_dval2, 0);
      chk("t1_ipg_rdreq", in_rdreq2, 0);
    end
    wait_idle(2, "t1_idle");

    // Single SOP+EOP word, padded to four bytes
    pl.delete();
    pl.push_back(8'h00);
    pl.push_back(8'h00);
    exp_frame(2, 4, 1'b0);
    buf2.push_back({2'b11, 16'h0000});
    wait_exp(2, "t2_drain");
    wait_idle(2, "t2_idle");

    // Wide words, buffer always ready
    rq4.delete();
    pl.delete();
    for (int i = 1; i <= 12; i++) pl.push_back(8'(i));
    exp_frame(4, 0, 1'b0);
    buf4.push_back({2'b10, 32'h01020304});
    buf4.push_back({2'b00, 32'h05060708});
    buf4.push_back({2'b01, 32'h090A0B0C});
    wait_exp(4, "t3_drain");
    chk("t3_rdreq_count", rq4.size(), 2);
    if (rq4.size() >= 2) chk("t3_rdreq_spacing", rq4[1] - rq4[0], 4);
    wait_idle(4, "t3_idle");

    // Underrun: the second request goes unanswered
    d0 = drops2;
    pl.delete();
    pl.push_back(8'h12);
    pl.push_back(8'h34);
    exp_frame(2, 4, 1'b1);
    buf2.push_back({2'b10, 16'h1234});
    wait_exp(2, "t4_drain");
    wait_idle(2, "t4_idle");
    chk("t4_no_idle_err", drops2 - d0, 0);

    // Non-SOP word in IDLE is dropped with an error pulse
    d0 = drops2;
    buf2.push_back({2'b00, 16'hBEEF});
    repeat (12) @(posedge clk_12_5m);
    chk("t5_drop_pulse", drops2 - d0, 1);
    chk("t5_word_taken", buf2.size(), 0);
    chk("t5_stay_idle", tx_busy2, 0);

    // SOP in the middle of a frame
    d0 = drops2;
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'hAA);
    exp_frame(2, 4, 1'b1);
    buf2.push_back({2'b10, 16'hAAAA});
    buf2.push_back({2'b10, 16'hBBBB});
    wait_exp(2, "t6_drain");
    wait_idle(2, "t6_idle");
    chk("t6_no_idle_err", drops2 - d0, 0);
    chk("t6_buf_empty", buf2.size(), 0);

    // Reset while the FCS is going out
    pl.delete();
    pl.push_back(8'hA5);
    pl.push_back(8'hA5);
    pl.push_back(8'h5A);
    pl.push_back(8'h5A);
    exp_frame(2, 4, 1'b0);
    buf2.push_back({2'b10, 16'hA5A5});
    buf2.push_back({2'b01, 16'h5A5A});
    n = 0;
    do begin
      @(negedge clk_12_5m);
      #1;
      n++;
    end while (exp2.size() != 5 && n < 200);
    chk("t7_reach_fcs", 32'(n < 200), 1);
    rst_12_5m = 1'b0;
    #1;
    chk("t7_rst_data", out_data2, 0);
    chk("t7_rst_dval", out_dval2, 0);
    chk("t7_rst_eop", tx_eop2, 0);
    chk("t7_rst_err", tx_err2, 0);
    chk("t7_rst_busy", tx_busy2, 0);
    chk("t7_rst_rdreq", in_rdreq2, 0);
    exp2.delete();
    d0 = drops2;
    repeat (2) @(posedge clk_12_5m);
    @(negedge clk_12_5m);
    rst_12_5m = 1'b1;
    repeat (4) @(posedge clk_12_5m);
    chk("t7_no_err_after_rst", drops2 - d0, 0);

    // Clean frame after reset
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'h00);
    exp_frame(2, 4, 1'b0);
    buf2.push_back({2'b10, 16'h0000});
    buf2.push_back({2'b01, 16'h0000});
    wait_exp(2, "t8_drain");
    wait_idle(2, "t8_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
